eth_rx_pcs_lock: RTL and testbench

ETH_RX_PCS_LOCK -- requirements
Module: eth_rx_pcs_lock

---
 rtl/eth_rx_pcs_lock.sv | 168 ++++++++++++++++
 tb/tb_eth_rx_pcs_lock.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_pcs_lock.sv
// eth_rx_pcs_lock: 64b/66b receive block-lock FSM with self-synchronising descrambler.
//
// Hunts for block lock on the 2-bit sync headers delivered by the gearbox. A bad header
// while hunting requests a one-bit gearbox slip and holds off evaluation for SLIP_WAIT
// cycles. Once locked, lock is dropped when BAD_LIMIT invalid headers are seen within a
// 64-header window. Payload words are descrambled (1 + x^39 + x^58) on every valid beat.
// Outputs are registered and appear one cycle after the input beat. Output valids are
// gated by the lock state on that beat.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_data[31:0], i_data_valid   scrambled payload beat (bit 0 first on the wire)
//   i_header[1:0], i_header_valid sync header, valid on the first beat of each block
//   o_data[31:0], o_data_valid   descrambled payload beat
//   o_header[1:0], o_header_valid registered sync header
//   o_bitslip                    one-cycle slip request to the gearbox
//   o_block_lock                 block lock status
module eth_rx_pcs_lock #(
  parameter int unsigned LOCK_COUNT = 64,
  parameter int unsigned BAD_LIMIT  = 16,
  parameter int unsigned SLIP_WAIT  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  output logic [1:0]  o_header,
  output logic        o_header_valid,
  output logic        o_bitslip,
  output logic        o_block_lock
);

  localparam int unsigned GW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW  = $clog2(BAD_LIMIT + 1);
  localparam int unsigned WW  = $clog2(SLIP_WAIT + 1);
  localparam int unsigned WIN = 64;

  localparam logic [1:0] UNLOCKED  = 2'd0;
  localparam logic [1:0] SLIP_HOLD = 2'd1;
  localparam logic [1:0] LOCKED    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [6:0]    win_q, win_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          slip_q, slip_d;
  logic [57:0]   hist_q;
  logic [89:0]   ext;
  logic [31:0]   descr;
  logic          eval, hdr_ok, locked;

  assign locked = (state_q == LOCKED);
  assign eval   = i_data_valid & i_header_valid & (state_q != SLIP_HOLD);
  assign hdr_ok = ^i_header;  // only 01 and 10 are legal sync headers

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    bad_d   = bad_q;
    wait_d  = wait_q;
    slip_d  = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (eval) begin
          if (hdr_ok) begin
            if (good_q == GW'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            state_d = SLIP_HOLD;
            good_d  = '0;
            wait_d  = '0;
            slip_d  = 1'b1;
          end
        end
      end
      SLIP_HOLD: begin
        if (wait_q == WW'(SLIP_WAIT - 1)) begin
          state_d = UNLOCKED;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      LOCKED: begin
        if (eval) begin
          // Loss of lock wins over a window clear on the same header.
          if (!hdr_ok && (bad_q == BW'(BAD_LIMIT - 1))) begin
            state_d = SLIP_HOLD;
            win_d   = '0;
            bad_d   = '0;
            wait_d  = '0;
            slip_d  = 1'b1;
          end else if (win_q == 7'(WIN - 1)) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            if (!hdr_ok) begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = UNLOCKED;
        good_d  = '0;
        win_d   = '0;
        bad_d   = '0;
        wait_d  = '0;
      end
    endcase
  end

  // Previous 58 received bits sit below the new word, oldest at bit 0, so stream bit
  // n-39 of payload bit i is ext[i+19] and bit n-58 is ext[i].
  assign ext = {i_data, hist_q};

  always_comb begin
    descr = '0;
    for (int i = 0; i < 32; i++) begin
      descr[i] = ext[58+i] ^ ext[i+19] ^ ext[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= UNLOCKED;
      good_q         <= '0;
      win_q          <= '0;
      bad_q          <= '0;
      wait_q         <= '0;
      slip_q         <= 1'b0;
      hist_q         <= '0;
      o_data         <= '0;
      o_header       <= '0;
      o_data_valid   <= 1'b0;
      o_header_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      good_q         <= good_d;
      win_q          <= win_d;
      bad_q          <= bad_d;
      wait_q         <= wait_d;
      slip_q         <= slip_d;
      o_data_valid   <= i_data_valid & locked;
      o_header_valid <= i_data_valid & i_header_valid & locked;
      if (i_data_valid) begin
        hist_q   <= ext[89:32];
        o_data   <= descr;
        o_header <= i_header;
      end
    end
  end

  assign o_bitslip    = slip_q;
  assign o_block_lock = locked;

endmodule

// File: tb/tb_eth_rx_pcs_lock.sv
// Testbench for eth_rx_pcs_lock: scrambles known payloads with a reference scrambler and
// tracks lock behaviour with a header-window model.
module tb_eth_rx_pcs_lock;
  localparam int unsigned LOCK_COUNT = 64;
  localparam int unsigned BAD_LIMIT  = 16;
  localparam int unsigned SLIP_WAIT  = 32;
  localparam int HUNT = 0, HOLD = 1, LOCK = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic [1:0]  i_header = '0;
  logic        i_header_valid = 1'b0;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [1:0]  o_header;
  logic        o_header_valid;
  logic        o_bitslip;
  logic        o_block_lock;

  eth_rx_pcs_lock #(
    .LOCK_COUNT(LOCK_COUNT),
    .BAD_LIMIT (BAD_LIMIT),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .i_header      (i_header),
    .i_header_valid(i_header_valid),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_header      (o_header),
    .o_header_valid(o_header_valid),
    .o_bitslip     (o_bitslip),
    .o_block_lock  (o_block_lock)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_state, m_good, m_hold, beat_idx;
  bit          m_win[$];
  bit          sq[$];
  logic        e_lock, e_slip, e_dv, e_hv, e_chk;
  logic [31:0] e_data, cur_payload;
  logic [1:0]  e_hdr;
  bit          idle_mode = 0;
  bit          wbad[64];
  logic [31:0] idle_words[4] = '{32'h0000001E, 32'h00000000, 32'h55555578, 32'hD5555555};

  function automatic logic [1:0] good_hdr(input int k);
    return (k % 2) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  // Reference scrambler: s[n] = p[n] ^ s[n-39] ^ s[n-58], history in a 58-entry queue.
  function automatic logic [31:0] scramble(input logic [31:0] p);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) begin
      s[i] = p[i] ^ sq[19] ^ sq[0];
      sq.push_back(s[i]);
      void'(sq.pop_front());
    end
    return s;
  endfunction

  task automatic model_reset();
    m_state = HUNT; m_good = 0; m_hold = 0; m_win.delete(); beat_idx = 0;
    e_lock = 0; e_slip = 0; e_dv = 0; e_hv = 0; e_chk = 0; e_data = '0; e_hdr = '0;
  endtask

  task automatic enter_hold();
    e_slip = 1'b1; m_state = HOLD; m_hold = SLIP_WAIT; m_good = 0; m_win.delete();
  endtask

  task automatic model_edge(input logic dv, input logic hv, input logic [1:0] hdr);
    int nbad;
    bit ok;
    ok = (hdr == 2'b01) || (hdr == 2'b10);
    e_slip = 1'b0;
    e_dv = dv && (m_state == LOCK);
    e_hv = dv && hv && (m_state == LOCK);
    if (dv) begin
      e_data = cur_payload; e_hdr = hdr; e_chk = (beat_idx >= 2); beat_idx++;
    end
    if (m_state == HOLD) begin
      m_hold--;
      if (m_hold == 0) m_state = HUNT;
    end else if (dv && hv) begin
      if (m_state == HUNT) begin
        if (ok) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin m_state = LOCK; m_good = 0; m_win.delete(); end
        end else begin
          enter_hold();
        end
      end else begin
        m_win.push_back(ok);
        nbad = 0;
        foreach (m_win[i]) if (!m_win[i]) nbad++;
        if (nbad == BAD_LIMIT) enter_hold();
        else if (m_win.size() == 64) m_win.delete();
      end
    end
    e_lock = (m_state == LOCK);
  endtask

  task automatic beat(input logic dv, input logic hv, input logic [1:0] hdr);
    cur_payload = idle_mode ? idle_words[$urandom_range(0, 3)] : $urandom();
    i_data_valid = dv; i_header_valid = hv; i_header = hdr;
    if (dv) i_data = scramble(cur_payload);
    else i_data = $urandom();
    @(posedge i_clk);
    model_edge(dv, hv, hdr);
    @(negedge i_clk);
  endtask

  task automatic drive_block(input logic [1:0] hdr);
    beat(1'b1, 1'b1, hdr);
    beat(1'b1, 1'b0, 2'($urandom()));
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_data_valid = 0; i_header_valid = 0; i_header = '0; i_data = '0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic lock_up();
    for (int k = 0; k < 64; k++) drive_block(good_hdr(k));
  endtask

  // nbad invalid positions in a 64-header window; force_last puts one of them at 63.
  task automatic fill_window(input int nbad, input bit force_last);
    int span, j;
    bit t;
    span = force_last ? 63 : 64;
    foreach (wbad[i]) wbad[i] = 0;
    for (int i = 0; i < (force_last ? nbad - 1 : nbad); i++) wbad[i] = 1;
    for (int i = span - 1; i > 0; i--) begin
      j = $urandom_range(0, i); t = wbad[i]; wbad[i] = wbad[j]; wbad[j] = t;
    end
    if (force_last) wbad[63] = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({o_data, o_header, o_data_valid, o_header_valid, o_bitslip, o_block_lock} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got data=%h hdr=%b dv=%b hv=%b slip=%b lock=%b required all 0",
               o_data, o_header, o_data_valid, o_header_valid, o_bitslip, o_block_lock);
    end
  endtask

  task automatic test_lock_acquire();
    apply_reset();
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (b == 0) beat(1'b1, 1'b1, good_hdr(k));
        else beat(1'b1, 1'b0, 2'($urandom()));
        n_cmp++;
        if ({o_block_lock, o_bitslip, o_data_valid, o_header_valid} !==
            {e_lock, e_slip, e_dv, e_hv}) begin
          n_bad++;
          $display("FAIL acq_ctrl k=%0d b=%0d got lock/slip/dv/hv=%b required %b", k, b,
                   {o_block_lock, o_bitslip, o_data_valid, o_header_valid},
                   {e_lock, e_slip, e_dv, e_hv});
        end
        n_cmp++;
        if (o_block_lock !== (k == 63) || o_data_valid !== (k == 63 && b == 1)) begin
          n_bad++;
          $display("FAIL acq_timing k=%0d b=%0d got lock=%b dv=%b required lock=%b dv=%b", k, b,
                   o_block_lock, o_data_valid, (k == 63), (k == 63 && b == 1));
        end
        if (e_dv && e_chk) begin
          n_cmp++;
          if (o_data !== e_data) begin
            n_bad++;
            $display("FAIL acq_data got %h required %h", o_data, e_data);
          end
        end
      end
    end
  endtask

  task automatic test_slip();
    int slips;
    apply_reset();
    for (int k = 0; k < 10; k++) drive_block(good_hdr(k));
    beat(1'b1, 1'b1, 2'b00);
    n_cmp++;
    if (o_bitslip !== 1'b1 || o_block_lock !== 1'b0) begin
      n_bad++;
      $display("FAIL slip_pulse got slip=%b lock=%b required slip=1 lock=0", o_bitslip,
               o_block_lock);
    end
    // Hold-off: invalid headers on every cycle must be ignored.
    slips = 0;
    for (int c = 0; c < SLIP_WAIT; c++) begin
      beat(1'b1, 1'b1, bad_hdr());
      if (o_bitslip) slips++;
      n_cmp++;
      if ({o_block_lock, o_bitslip, o_data_valid, o_header_valid} !==
          {e_lock, e_slip, e_dv, e_hv}) begin
        n_bad++;
        $display("FAIL slip_hold c=%0d got lock/slip/dv/hv=%b required %b", c,
                 {o_block_lock, o_bitslip, o_data_valid, o_header_valid},
                 {e_lock, e_slip, e_dv, e_hv});
      end
    end
    n_cmp++;
    if (slips != 0) begin
      n_bad++;
      $display("FAIL slip_holdoff got %0d slips during hold-off required 0", slips);
    end
    // Good count restarts from zero: 63 headers do not lock, the 64th does.
    for (int k = 0; k < 64; k++) begin
      beat(1'b1, 1'b1, good_hdr(k));
      n_cmp++;
      if (o_block_lock !== (k == 63) || o_bitslip !== 1'b0 || o_block_lock !== e_lock) begin
        n_bad++;
        $display("FAIL slip_relock k=%0d got lock=%b slip=%b required lock=%b slip=0", k,
                 o_block_lock, o_bitslip, (k == 63));
      end
      beat(1'b1, 1'b0, 2'b01);
    end
  endtask

  task automatic test_bad_window();
    int slips;
    apply_reset();
    lock_up();
    for (int w = 0; w < 2; w++) begin
      fill_window(15 + w, 1'b0);
      slips = 0;
      for (int k = 0; k < 64; k++) begin
        drive_block(wbad[k] ? bad_hdr() : good_hdr(k));
        if (o_bitslip) slips++;
        n_cmp++;
        if ({o_block_lock, o_bitslip, o_data_valid, o_header_valid} !==
            {e_lock, e_slip, e_dv, e_hv}) begin
          n_bad++;
          $display("FAIL win_ctrl w=%0d k=%0d got lock/slip/dv/hv=%b required %b", w, k,
                   {o_block_lock, o_bitslip, o_data_valid, o_header_valid},
                   {e_lock, e_slip, e_dv, e_hv});
        end
        if (e_dv && e_chk) begin
          n_cmp++;
          if (o_data !== e_data) begin
            n_bad++;
            $display("FAIL win_data got %h required %h", o_data, e_data);
          end
        end
      end
      n_cmp++;
      if (o_block_lock !== (w == 0)) begin
        n_bad++;
        $display("FAIL win_result w=%0d got lock=%b required %b", w, o_block_lock, (w == 0));
      end
      if (w == 0) begin
        n_cmp++;
        if (slips != 0) begin
          n_bad++;
          $display("FAIL win15_slips got %0d required 0", slips);
        end
      end
    end
  endtask

  task automatic test_window_boundary();
    apply_reset();
    lock_up();
    fill_window(15, 1'b0);
    for (int k = 0; k < 64; k++) drive_block(wbad[k] ? bad_hdr() : good_hdr(k));
    fill_window(16, 1'b1);
    for (int k = 0; k < 64; k++) begin
      beat(1'b1, 1'b1, wbad[k] ? bad_hdr() : good_hdr(k));
      n_cmp++;
      if (o_block_lock !== (k != 63) || o_bitslip !== (k == 63) || o_bitslip !== e_slip) begin
        n_bad++;
        $display("FAIL boundary k=%0d got lock=%b slip=%b required lock=%b slip=%b", k,
                 o_block_lock, o_bitslip, (k != 63), (k == 63));
      end
      beat(1'b1, 1'b0, 2'b10);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lock_up();
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_data, o_header, o_data_valid, o_header_valid, o_bitslip, o_block_lock} !== 38'd0) begin
      n_bad++;
      $display("FAIL rst_locked got lock=%b dv=%b data=%h required all 0", o_block_lock,
               o_data_valid, o_data);
    end
    apply_reset();
    beat(1'b1, 1'b1, 2'b11);
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_data, o_header, o_data_valid, o_header_valid, o_bitslip, o_block_lock} !== 38'd0) begin
      n_bad++;
      $display("FAIL rst_slip got slip=%b lock=%b required all 0", o_bitslip, o_block_lock);
    end
    apply_reset();
    for (int k = 0; k < 64; k++) begin
      drive_block(good_hdr(k));
      n_cmp++;
      if (o_block_lock !== (k == 63) || o_block_lock !== e_lock || o_bitslip !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_relock k=%0d got lock=%b slip=%b required lock=%b slip=0", k,
                 o_block_lock, o_bitslip, (k == 63));
      end
    end
  endtask

  task automatic test_descramble_random();
    bit ph, dv, hv;
    apply_reset();
    idle_mode = 1;
    ph = 0;
    for (int n = 0; n < 1500; n++) begin
      dv = ($urandom_range(0, 7) != 0);
      hv = dv && !ph;
      if (dv) ph = ~ph;
      // Clean headers first to get locked, then a mix that can lose lock.
      if (n < 130 || $urandom_range(0, 99) >= 18) beat(dv, hv, good_hdr(n));
      else beat(dv, hv, bad_hdr());
      n_cmp++;
      if ({o_block_lock, o_bitslip, o_data_valid, o_header_valid} !==
          {e_lock, e_slip, e_dv, e_hv}) begin
        n_bad++;
        $display("FAIL rnd_ctrl n=%0d got lock/slip/dv/hv=%b required %b", n,
                 {o_block_lock, o_bitslip, o_data_valid, o_header_valid},
                 {e_lock, e_slip, e_dv, e_hv});
      end
      if (e_dv && e_chk) begin
        n_cmp++;
        if (o_data !== e_data) begin
          n_bad++;
          $display("FAIL rnd_data n=%0d got %h required %h", n, o_data, e_data);
        end
      end
      if (e_hv) begin
        n_cmp++;
        if (o_header !== e_hdr) begin
          n_bad++;
          $display("FAIL rnd_header n=%0d got %b required %b", n, o_header, e_hdr);
        end
      end
    end
    idle_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 58; i++) sq.push_back(1'($urandom()));
    model_reset();
    @(negedge i_clk);
    test_reset();
    test_lock_acquire();
    test_slip();
    test_bad_window();
    test_window_boundary();
    test_reset_mid();
    test_descramble_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
